// File: rtl/lvds_pattern_gen_pkg.sv
// Shared definitions for the LVDS test-pattern generator: pattern modes,
// colour-bar boundaries and the bar colour table.
package lvds_pattern_gen_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID    = 2'd0,
        MODE_BARS     = 2'd1,
        MODE_GRADIENT = 2'd2,
        MODE_CHECKER  = 2'd3
    } mode_e;

    localparam logic [17:0] RGB_WHITE = 18'h3FFFF;
    localparam logic [17:0] RGB_BLACK = 18'h00000;

    // Left edge of bar k on a line of screen_x pixels (integer division).
    function automatic logic [10:0] bar_bound(input int k, input int screen_x);
        return 11'((k * screen_x) / 8);
    endfunction

    // Bar colours {R,G,B}, white first, black last.
    function automatic logic [17:0] bar_rgb(input logic [2:0] idx);
        logic [17:0] rgb;
        case (idx)
            3'd0:    rgb = {6'd63, 6'd63, 6'd63};
            3'd1:    rgb = {6'd63, 6'd63, 6'd0};
            3'd2:    rgb = {6'd0,  6'd63, 6'd63};
            3'd3:    rgb = {6'd0,  6'd63, 6'd0};
            3'd4:    rgb = {6'd63, 6'd0,  6'd63};
            3'd5:    rgb = {6'd63, 6'd0,  6'd0};
            3'd6:    rgb = {6'd0,  6'd0,  6'd63};
            3'd7:    rgb = {6'd0,  6'd0,  6'd0};
            default: rgb = RGB_BLACK;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/lvds_pattern_gen_word_pack.sv
// Bit mapping of RGB666 plus sync/DE into the 21-bit word of the 7:1 LVDS
// transmitter; purely combinational so any upstream video source can reuse it.
module lvds_word_pack (
    input  logic [5:0]  red,
    input  logic [5:0]  green,
    input  logic [5:0]  blue,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        de,
    output logic [20:0] word
);

    assign word = {blue[2], blue[3], blue[4], blue[5], hsync, vsync, de,
                   green[1], green[2], green[3], green[4], green[5], blue[0], blue[1],
                   red[0], red[1], red[2], red[3], red[4], red[5], green[0]};

endmodule

// File: rtl/lvds_pattern_gen.sv
// Two-stage test-pattern generator feeding the LVDS serializer: stage 1 registers
// timing and pixel/line counters, stage 2 registers the pattern colour.
module lvds_pattern_gen
    import lvds_pattern_gen_pkg::*;
#(
    parameter int SCREEN_X    = 1366,
    parameter int SCREEN_Y    = 768,
    parameter int CHECK_SHIFT = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        de_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [1:0]  mode_in,
    input  logic [17:0] solid_rgb,
    output logic [5:0]  red_out,
    output logic [5:0]  green_out,
    output logic [5:0]  blue_out,
    output logic        de_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic [20:0] video_data,
    output logic        frame_start,
    output logic        line_err
);

    logic        de1_r, hs1_r, vs1_r, frame_start_r, line_err_r;
    logic [10:0] x_r;
    logic [9:0]  y_r;
    mode_e       mode_r;
    logic [17:0] solid_r;
    logic        de2_r, hs2_r, vs2_r;
    logic [17:0] rgb2_r;

    logic        vs_rise_s, de_fall_s, line_err_s;
    logic [10:0] x_next_s;
    logic [9:0]  y_next_s;
    logic [2:0]  bar_idx_s;
    logic [17:0] pat_s, pix_s;

    // Edge detection and next-state of the pixel/line counters and line check.
    always_comb begin
        vs_rise_s = vsync_in & ~vs1_r;
        de_fall_s = de1_r & ~de_in;
        if (!de_in || !de1_r) begin
            x_next_s = 11'd0;
        end else if (x_r == 11'h7FF) begin
            x_next_s = x_r;
        end else begin
            x_next_s = x_r + 11'd1;
        end
        if (vs_rise_s) begin
            y_next_s = 10'd0;
        end else if (de_fall_s && (y_r < 10'(SCREEN_Y - 1))) begin
            y_next_s = y_r + 10'd1;
        end else begin
            y_next_s = y_r;
        end
        // x holds run length minus one at the falling edge; saturation forces a mismatch.
        line_err_s = line_err_r | (de_fall_s & (x_r != 11'(SCREEN_X - 1)));
    end

    // Stage 1: timing registers, counters and per-frame configuration latch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            de1_r         <= 1'b0;
            hs1_r         <= 1'b0;
            vs1_r         <= 1'b0;
            frame_start_r <= 1'b0;
            line_err_r    <= 1'b0;
            x_r           <= 11'd0;
            y_r           <= 10'd0;
            mode_r        <= MODE_SOLID;
            solid_r       <= 18'd0;
        end else begin
            de1_r         <= de_in;
            hs1_r         <= hsync_in;
            vs1_r         <= vsync_in;
            frame_start_r <= vs_rise_s;
            line_err_r    <= line_err_s;
            x_r           <= x_next_s;
            y_r           <= y_next_s;
            if (vs_rise_s) begin
                mode_r  <= mode_e'(mode_in);
                solid_r <= solid_rgb;
            end
        end
    end

    // Colour selection from stage-1 position and latched mode; blanking forces black.
    always_comb begin
        bar_idx_s = 3'd0;
        for (int k = 1; k < 8; k++) begin
            bar_idx_s = bar_idx_s + {2'b00, (x_r >= bar_bound(k, SCREEN_X))};
        end
        case (mode_r)
            MODE_SOLID:    pat_s = solid_r;
            MODE_BARS:     pat_s = bar_rgb(bar_idx_s);
            MODE_GRADIENT: pat_s = {x_r[9:4], x_r[9:4], x_r[9:4]};
            MODE_CHECKER:  pat_s = (x_r[CHECK_SHIFT] ^ y_r[CHECK_SHIFT]) ? RGB_WHITE : RGB_BLACK;
            default:       pat_s = RGB_BLACK;
        endcase
        if (de1_r) begin
            pix_s = pat_s;
        end else begin
            pix_s = RGB_BLACK;
        end
    end

    // Stage 2: colour and timing registered together so they stay aligned.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            de2_r  <= 1'b0;
            hs2_r  <= 1'b0;
            vs2_r  <= 1'b0;
            rgb2_r <= 18'd0;
        end else begin
            de2_r  <= de1_r;
            hs2_r  <= hs1_r;
            vs2_r  <= vs1_r;
            rgb2_r <= pix_s;
        end
    end

    assign red_out     = rgb2_r[17:12];
    assign green_out   = rgb2_r[11:6];
    assign blue_out    = rgb2_r[5:0];
    assign de_out      = de2_r;
    assign hsync_out   = hs2_r;
    assign vsync_out   = vs2_r;
    assign frame_start = frame_start_r;
    assign line_err    = line_err_r;

    lvds_word_pack u_pack (
        .red   (rgb2_r[17:12]),
        .green (rgb2_r[11:6]),
        .blue  (rgb2_r[5:0]),
        .hsync (hs2_r),
        .vsync (vs2_r),
        .de    (de2_r),
        .word  (video_data)
    );

endmodule

// File: tb/tb_lvds_pattern_gen.sv
// Directed bench for lvds_pattern_gen: reset, each pattern mode, frame-latched
// configuration, LVDS word packing and the line-length check.
module tb_lvds_pattern_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        de_in, hsync_in, vsync_in;
    logic [1:0]  mode_in;
    logic [17:0] solid_rgb;
    logic [5:0]  red_out, green_out, blue_out;
    logic        de_out, hsync_out, vsync_out, frame_start, line_err;
    logic [20:0] video_data;

    int checks = 0;
    int errors = 0;

    logic [17:0] cap_rgb [0:2047];
    logic [20:0] cap_vd  [0:2047];
    int          out_x    = 0;
    int          last_len = 0;
    int          fs_count = 0;
    int          fs_prev;
    bit          blank_nz = 1'b0;

    lvds_pattern_gen dut (
        .clk         (clk),
        .rst         (rst),
        .de_in       (de_in),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .mode_in     (mode_in),
        .solid_rgb   (solid_rgb),
        .red_out     (red_out),
        .green_out   (green_out),
        .blue_out    (blue_out),
        .de_out      (de_out),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out),
        .video_data  (video_data),
        .frame_start (frame_start),
        .line_err    (line_err)
    );

    always #5 clk = ~clk;

    // Capture each output line by output pixel index, away from the active edge.
    always @(negedge clk) begin
        if (de_out) begin
            if (out_x < 2048) begin
                cap_rgb[out_x] = {red_out, green_out, blue_out};
                cap_vd[out_x]  = video_data;
            end
            out_x = out_x + 1;
        end else begin
            if (out_x != 0) last_len = out_x;
            out_x = 0;
            if ({red_out, green_out, blue_out} != 18'd0) blank_nz = 1'b1;
        end
        if (frame_start) fs_count = fs_count + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_line(input int len);
        de_in = 1'b1;
        repeat (len) tick();
        de_in = 1'b0;
        repeat (8) tick();
    endtask

    task automatic do_vsync();
        vsync_in = 1'b1;
        repeat (3) tick();
        vsync_in = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        rst = 1'b1; de_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
        mode_in = 2'd0; solid_rgb = 18'd0;
        #3 rst = 1'b0;
        repeat (3) tick();
        chk("reset_rgb", {14'd0, red_out, green_out, blue_out}, 32'd0);
        chk("reset_sync", {29'd0, de_out, hsync_out, vsync_out}, 32'd0);
        chk("reset_word", {11'd0, video_data}, 32'd0);
        chk("reset_flags", {30'd0, frame_start, line_err}, 32'd0);
        rst = 1'b1;
        tick();

        // Sync delay and frame_start pulse, latching bars mode.
        mode_in = 2'd1;
        vsync_in = 1'b1;
        tick();
        chk("vs_stage1", {30'd0, vsync_out, frame_start}, 32'd1);
        tick();
        chk("vs_stage2", {30'd0, vsync_out, frame_start}, 32'd2);
        vsync_in = 1'b0;
        repeat (3) tick();
        hsync_in = 1'b1;
        tick();
        chk("hs_delay1", {31'd0, hsync_out}, 32'd0);
        tick();
        chk("hs_delay2", {31'd0, hsync_out}, 32'd1);
        hsync_in = 1'b0;
        repeat (3) tick();

        // Colour bars.
        drive_line(1366);
        chk("bars_len", last_len, 32'd1366);
        chk("bars_px0", {14'd0, cap_rgb[0]}, {14'd0, 18'h3FFFF});
        chk("bars_px169", {14'd0, cap_rgb[169]}, {14'd0, 18'h3FFFF});
        chk("bars_px170", {14'd0, cap_rgb[170]}, {14'd0, 18'h3FFC0});
        chk("bars_px171", {14'd0, cap_rgb[171]}, {14'd0, 18'h3FFC0});
        chk("bars_px512", {14'd0, cap_rgb[512]}, {14'd0, 18'h00FC0});
        chk("bars_px1365", {14'd0, cap_rgb[1365]}, 32'd0);
        chk("word_px0", {11'd0, cap_vd[0]}, {11'd0, 21'h1E7FFF});
        chk("bars_line_err", {31'd0, line_err}, 32'd0);

        // Mid-frame mode change is ignored until the next frame.
        mode_in = 2'd0;
        solid_rgb = 18'h2A5C3;
        fs_prev = fs_count;
        drive_line(1366);
        chk("midframe_px0", {14'd0, cap_rgb[0]}, {14'd0, 18'h3FFFF});
        chk("midframe_no_fs", fs_count, fs_prev);
        do_vsync();
        chk("fs_once", fs_count, fs_prev + 1);
        drive_line(1366);
        chk("solid_px0", {14'd0, cap_rgb[0]}, {14'd0, 18'h2A5C3});
        chk("solid_px1000", {14'd0, cap_rgb[1000]}, {14'd0, 18'h2A5C3});

        // Gradient.
        mode_in = 2'd2;
        do_vsync();
        drive_line(1366);
        chk("grad_x15", {14'd0, cap_rgb[15]}, 32'd0);
        chk("grad_x16", {14'd0, cap_rgb[16]}, {14'd0, 18'h01041});
        chk("grad_x1023", {14'd0, cap_rgb[1023]}, {14'd0, 18'h3FFFF});
        chk("grad_x1024", {14'd0, cap_rgb[1024]}, 32'd0);

        // Checkerboard: lines of 70 pixels reach y=64 quickly.
        mode_in = 2'd3;
        do_vsync();
        drive_line(70);
        chk("chk_0_0", {14'd0, cap_rgb[0]}, 32'd0);
        chk("chk_63_0", {14'd0, cap_rgb[63]}, 32'd0);
        chk("chk_64_0", {14'd0, cap_rgb[64]}, {14'd0, 18'h3FFFF});
        repeat (63) drive_line(70);
        drive_line(70);
        chk("chk_0_64", {14'd0, cap_rgb[0]}, {14'd0, 18'h3FFFF});
        chk("chk_64_64", {14'd0, cap_rgb[64]}, 32'd0);
        chk("short_line_err", {31'd0, line_err}, 32'd1);
        chk("blank_black", {31'd0, blank_nz}, 32'd0);

        // Reset mid-line clears everything immediately.
        de_in = 1'b1;
        repeat (500) tick();
        rst = 1'b0;
        #1;
        chk("rst_mid_rgb", {14'd0, red_out, green_out, blue_out}, 32'd0);
        chk("rst_mid_sync", {29'd0, de_out, hsync_out, vsync_out}, 32'd0);
        chk("rst_mid_word", {11'd0, video_data}, 32'd0);
        chk("rst_mid_flags", {30'd0, frame_start, line_err}, 32'd0);
        de_in = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        mode_in = 2'd2;
        do_vsync();
        drive_line(1366);
        chk("post_rst_x0", {14'd0, cap_rgb[0]}, 32'd0);
        chk("post_rst_x16", {14'd0, cap_rgb[16]}, {14'd0, 18'h01041});
        chk("post_rst_len", last_len, 32'd1366);
        chk("post_rst_err", {31'd0, line_err}, 32'd0);

        // Short run sets the sticky line error at the falling edge.
        de_in = 1'b1;
        repeat (1365) tick();
        chk("err_before_fall", {31'd0, line_err}, 32'd0);
        de_in = 1'b0;
        tick();
        chk("err_at_fall", {31'd0, line_err}, 32'd1);
        repeat (8) tick();
        drive_line(1366);
        chk("err_sticky", {31'd0, line_err}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
